// File: rtl/ac_control_unit_if.sv
// Control-unit bundle for the accumulator simulator: sequencing inputs from
// the datapath/memory and the register/memory strobes returned to them.
interface ac_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             run_i;
  logic [2:0]       opcode_i;
  logic             zero_i;
  logic             mem_ack_i;
  logic             pc_wen_o;
  logic             pc_sel_o;
  logic             mar_wen_o;
  logic             mar_sel_o;
  logic             ir_wen_o;
  logic             ac_wen_o;
  logic [1:0]       alu_op_o;
  logic             mem_rd_o;
  logic             mem_wr_o;
  logic             halted_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instr_cnt_o;

  // The control unit drives the strobes.
  modport master (
    input  run_i, opcode_i, zero_i, mem_ack_i,
    output pc_wen_o, pc_sel_o, mar_wen_o, mar_sel_o, ir_wen_o, ac_wen_o,
           alu_op_o, mem_rd_o, mem_wr_o, halted_o, state_o, instr_cnt_o
  );

  // The datapath/memory side consumes the strobes.
  modport slave (
    output run_i, opcode_i, zero_i, mem_ack_i,
    input  pc_wen_o, pc_sel_o, mar_wen_o, mar_sel_o, ir_wen_o, ac_wen_o,
           alu_op_o, mem_rd_o, mem_wr_o, halted_o, state_o, instr_cnt_o
  );
endinterface

// File: rtl/ac_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator machine with an
// ack-based memory handshake and a saturating retired-instruction counter.
module ac_control_unit #(
  parameter int CNT_W = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  ac_control_unit_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH0 = 3'd1;
  localparam logic [2:0] S_FETCH1 = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC0  = 3'd4;
  localparam logic [2:0] S_EXEC1  = 3'd5;
  localparam logic [2:0] S_STORE  = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  logic [2:0]       state, state_nxt, resume;
  logic [CNT_W-1:0] cnt;
  logic             pc_wen, pc_sel, mar_wen, mar_sel, ir_wen, ac_wen;
  logic             mem_rd, mem_wr;
  logic [1:0]       alu_op;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

  // Where an instruction goes once it has fully completed.
  assign resume = bus.run_i ? S_FETCH0 : S_IDLE;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    pc_wen    = 1'b0;
    pc_sel    = 1'b0;
    mar_wen   = 1'b0;
    mar_sel   = 1'b0;
    ir_wen    = 1'b0;
    ac_wen    = 1'b0;
    alu_op    = 2'b00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      S_IDLE: if (bus.run_i) state_nxt = S_FETCH0;
      S_FETCH0: begin
        mar_wen   = 1'b1;
        state_nxt = S_FETCH1;
      end
      S_FETCH1: begin
        mem_rd = 1'b1;
        if (bus.mem_ack_i) begin
          ir_wen    = 1'b1;
          pc_wen    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (bus.opcode_i)
          OP_JMP: begin
            pc_wen    = 1'b1;
            pc_sel    = 1'b1;
            state_nxt = resume;
          end
          OP_JZ: begin
            pc_wen    = bus.zero_i;
            pc_sel    = 1'b1;
            state_nxt = resume;
          end
          OP_HALT:                          state_nxt = S_HALT;
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_nxt = S_EXEC0;
          default:                          state_nxt = resume;
        endcase
      end
      S_EXEC0: begin
        mar_sel   = 1'b1;
        mar_wen   = 1'b1;
        state_nxt = (bus.opcode_i == OP_STORE) ? S_STORE : S_EXEC1;
      end
      S_EXEC1: begin
        mem_rd = 1'b1;
        case (bus.opcode_i)
          OP_ADD:  alu_op = 2'b01;
          OP_SUB:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
        if (bus.mem_ack_i) begin
          ac_wen    = 1'b1;
          state_nxt = resume;
        end
      end
      S_STORE: begin
        mem_wr = 1'b1;
        if (bus.mem_ack_i) state_nxt = resume;
      end
      S_HALT: if (!bus.run_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.pc_wen_o    = pc_wen;
  assign bus.pc_sel_o    = pc_sel;
  assign bus.mar_wen_o   = mar_wen;
  assign bus.mar_sel_o   = mar_sel;
  assign bus.ir_wen_o    = ir_wen;
  assign bus.ac_wen_o    = ac_wen;
  assign bus.alu_op_o    = alu_op;
  assign bus.mem_rd_o    = mem_rd;
  assign bus.mem_wr_o    = mem_wr;
  assign bus.halted_o    = (state == S_HALT);
  assign bus.state_o     = state;
  assign bus.instr_cnt_o = cnt;

endmodule

// File: tb/tb_ac_control_unit.sv
// Bench for ac_control_unit: directed instruction walks with literal checks plus
// randomized traffic compared every cycle against an instruction-route model.
module tb_ac_control_unit;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, JMP = 3'd5, JZ = 3'd6, HALT = 3'd7;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_wen, pc_sel, mar_wen, mar_sel, ir_wen, ac_wen;
    logic [1:0] alu;
    logic       rd, wr, halted;
  } obs_t;

  typedef enum {M_IDLE, M_RUN, M_HALT} mode_e;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       run, zero, ack;
  logic [2:0] op;

  ac_control_unit_if #(.CNT_W(16)) bus ();
  ac_control_unit_if #(.CNT_W(2))  bus_s ();

  assign bus.run_i       = run;
  assign bus.opcode_i    = op;
  assign bus.zero_i      = zero;
  assign bus.mem_ack_i   = ack;
  assign bus_s.run_i     = run;
  assign bus_s.opcode_i  = op;
  assign bus_s.zero_i    = zero;
  assign bus_s.mem_ack_i = ack;

  ac_control_unit #(.CNT_W(16)) dut   (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  ac_control_unit #(.CNT_W(2))  dut_s (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_s));

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.state   = bus.state_o;
    o.pc_wen  = bus.pc_wen_o;
    o.pc_sel  = bus.pc_sel_o;
    o.mar_wen = bus.mar_wen_o;
    o.mar_sel = bus.mar_sel_o;
    o.ir_wen  = bus.ir_wen_o;
    o.ac_wen  = bus.ac_wen_o;
    o.alu     = bus.alu_op_o;
    o.rd      = bus.mem_rd_o;
    o.wr      = bus.mem_wr_o;
    o.halted  = bus.halted_o;
    return o;
  endfunction

  // Reference model: each instruction is a route of phases. Fetch is always
  // phases 1,2,3; decode appends the operand/memory phases for the opcode.
  mode_e m_mode = M_IDLE;
  int    route[$];
  int    m_dec = 0;

  function automatic int cur_state();
    if (m_mode == M_IDLE) return 0;
    if (m_mode == M_HALT) return 7;
    return route[0];
  endfunction

  function automatic obs_t model_obs(input int ph, input logic [2:0] o, input logic z, input logic a);
    obs_t e = '0;
    e.state = 3'(ph);
    case (ph)
      1: e.mar_wen = 1'b1;
      2: begin e.rd = 1'b1; e.ir_wen = a; e.pc_wen = a; end
      3: if (o == JMP) begin e.pc_wen = 1'b1; e.pc_sel = 1'b1; end
         else if (o == JZ) begin e.pc_wen = z; e.pc_sel = 1'b1; end
      4: begin e.mar_wen = 1'b1; e.mar_sel = 1'b1; end
      5: begin
        e.rd = 1'b1;
        e.ac_wen = a;
        e.alu = (o == ADD) ? 2'd1 : (o == SUB) ? 2'd2 : 2'd0;
      end
      6: e.wr = 1'b1;
      7: e.halted = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic void model_advance(input logic r, input logic [2:0] o, input logic a);
    int ph;
    case (m_mode)
      M_IDLE: if (r) begin route = '{1, 2, 3}; m_mode = M_RUN; end
      M_HALT: if (!r) m_mode = M_IDLE;
      default: begin
        ph = route[0];
        if (!((ph == 2 || ph == 5 || ph == 6) && !a)) begin
          if (ph == 3) begin
            m_dec++;
            if (o == LOAD || o == ADD || o == SUB) begin route.push_back(4); route.push_back(5); end
            else if (o == STORE) begin route.push_back(4); route.push_back(6); end
            else if (o == HALT) m_mode = M_HALT;
          end
          void'(route.pop_front());
          if (m_mode == M_RUN && route.size() == 0) begin
            if (r) route = '{1, 2, 3};
            else m_mode = M_IDLE;
          end
        end
      end
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_mode = M_IDLE;
      route.delete();
      m_dec = 0;
    end
    check("cycle_outputs", dut_obs(), model_obs(cur_state(), op, zero, ack));
    check("cycle_count", bus.instr_cnt_o, (m_dec > 65535) ? 65535 : m_dec);
    check("cycle_count_sat", bus_s.instr_cnt_o, (m_dec > 3) ? 3 : m_dec);
    if (rst_ni) model_advance(run, op, ack);
  end

  // Drive one cycle's inputs just after the rising edge, then sample mid-cycle.
  task automatic stp(input logic r, input logic [2:0] o, input logic z, input logic a,
                     input int exp_state, input string name);
    @(posedge clk_i);
    #2;
    run = r; op = o; zero = z; ack = a;
    @(negedge clk_i);
    #1;
    check(name, bus.state_o, exp_state);
  endtask

  int seq[7] = '{0, 1, 2, 3, 4, 5, 1};
  int acw, wrc;

  initial begin
    rst_ni = 1'b0; run = 1'b0; op = NOP; zero = 1'b0; ack = 1'b0;
    #1;
    check("reset_outputs", dut_obs(), '0);
    check("reset_count", bus.instr_cnt_o, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    #1 check("idle_after_reset", bus.state_o, 0);

    // LOAD with zero-wait memory
    acw = 0;
    for (int i = 0; i < 7; i++) begin
      stp(1, LOAD, 0, 1, seq[i], "load_state");
      acw += int'(bus.ac_wen_o);
      if (seq[i] == 5) begin
        check("load_acwen", bus.ac_wen_o, 1);
        check("load_aluop", bus.alu_op_o, 0);
      end
    end
    check("load_acwen_pulses", acw, 1);
    check("load_count", bus.instr_cnt_o, 1);

    // STORE with the write ack delayed three cycles; ack during EXEC0 is ignored
    stp(1, STORE, 0, 1, 2, "store_f1");
    stp(1, STORE, 0, 1, 3, "store_dec");
    stp(1, STORE, 0, 1, 4, "store_e0");
    acw = 0; wrc = 0;
    for (int i = 0; i < 4; i++) begin
      stp(1, STORE, 0, (i == 3), 6, "store_wait");
      wrc += int'(bus.mem_wr_o);
      acw += int'(bus.ac_wen_o);
    end
    check("store_wr_cycles", wrc, 4);
    check("store_no_acwen", acw, 0);
    stp(1, JZ, 1, 1, 1, "store_next_f0");

    // JZ taken and not taken, three cycles each
    stp(1, JZ, 1, 1, 2, "jz1_f1");
    stp(1, JZ, 1, 1, 3, "jz1_dec");
    check("jz1_pc", {bus.pc_wen_o, bus.pc_sel_o}, 2'b11);
    stp(1, JZ, 0, 1, 1, "jz1_back_f0");
    stp(1, JZ, 0, 1, 2, "jz0_f1");
    stp(1, JZ, 0, 1, 3, "jz0_dec");
    check("jz0_pc", {bus.pc_wen_o, bus.pc_sel_o}, 2'b01);
    stp(1, NOP, 0, 0, 1, "jz0_back_f0");

    // Asynchronous reset in the middle of a fetch wait
    stp(1, NOP, 0, 0, 2, "fetch_wait");
    check("fetch_wait_rd", bus.mem_rd_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_outputs", dut_obs(), '0);
    check("async_reset_count", bus.instr_cnt_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_ni = 1'b1; run = 1'b0;
    @(negedge clk_i);
    #1 check("idle_after_async_reset", bus.state_o, 0);

    // Program ADD, SUB, HALT
    stp(1, ADD, 0, 1, 0, "add_idle");
    for (int s = 1; s <= 5; s++) stp(1, ADD, 0, 1, s, "add_state");
    check("add_acwen_alu", {bus.ac_wen_o, bus.alu_op_o}, 3'b101);
    for (int s = 1; s <= 5; s++) stp(1, SUB, 0, 1, s, "sub_state");
    check("sub_acwen_alu", {bus.ac_wen_o, bus.alu_op_o}, 3'b110);
    for (int s = 1; s <= 3; s++) stp(1, HALT, 0, 1, s, "halt_fetch");
    for (int i = 0; i < 4; i++) stp(1, HALT, 0, 1, 7, "halt_hold");
    check("halted", bus.halted_o, 1);
    check("halt_count", bus.instr_cnt_o, 3);
    stp(0, HALT, 0, 1, 7, "halt_release");
    stp(0, HALT, 0, 1, 0, "halt_to_idle");
    check("idle_count_kept", bus.instr_cnt_o, 3);
    check("idle_not_halted", bus.halted_o, 0);

    // Five NOPs: the 2-bit counter saturates at 3
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    stp(1, NOP, 0, 1, 0, "nop_idle");
    for (int k = 0; k < 5; k++)
      for (int s = 1; s <= 3; s++) stp(1, NOP, 0, 1, s, "nop_state");
    stp(0, NOP, 0, 1, 1, "nop_after");
    check("sat_count", bus_s.instr_cnt_o, 3);
    check("wide_count", bus.instr_cnt_o, 5);

    // Randomized traffic; the per-cycle model compare does the checking
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk_i);
      #2;
      if (!rst_ni) rst_ni = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst_ni = 1'b0;
      run  = ($urandom_range(0, 9) != 0);
      zero = 1'($urandom_range(0, 1));
      ack  = ($urandom_range(0, 2) != 0);
      if (cur_state() <= 2) begin
        op = 3'($urandom_range(0, 6));
        if ($urandom_range(0, 15) == 0) op = HALT;
      end
    end
    @(negedge clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
